// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX state type, divisor and frame helpers.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int unsigned frame_cycles(input int unsigned div,
                                               input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with asynchronous active-high reset; head word read straight from storage.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO; back-to-back frames with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [7:0]                          data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  output logic                                uart_txd_o,
  output logic                                busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count_o
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned BW  = $clog2(DIV);
  localparam logic [7:0]  DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;

  logic [7:0]    head;
  logic          head_par;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          baud_wrap;
  logic          last_data;
  logic          last_stop;

  assign ready_o   = !fifo_full;
  assign push      = valid_i && ready_o;
  assign baud_wrap = (baud_cnt == BW'(DIV - 1));
  assign last_data = (bit_cnt == 3'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 3'(STOP_BITS - 1));
  assign head_par  = (PARITY == PARITY_ODD) ? ~(^head) : (^head);
  assign pop       = !fifo_empty &&
                     ((state == ST_IDLE) || (state == ST_STOP && baud_wrap && last_stop));
  assign busy_o    = (state != ST_IDLE) || (fifo_count_o != '0);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (data_i & DATA_MASK),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  // Line flop follows the current state, so the wire lags each state change by one edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      uart_txd_o <= 1'b1;
    end else begin
      unique case (state)
        ST_START: uart_txd_o <= 1'b0;
        ST_DATA:  uart_txd_o <= shift[0];
        ST_PAR:   uart_txd_o <= par_bit;
        default:  uart_txd_o <= 1'b1;
      endcase

      if (state == ST_IDLE || baud_wrap) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + BW'(1);

      if (pop) begin
        shift    <= head;
        par_bit  <= head_par;
        bit_cnt  <= '0;
        baud_cnt <= '0;
        state    <= ST_START;
      end else begin
        unique case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_START: begin
            if (baud_wrap) state <= ST_DATA;
          end
          ST_DATA: begin
            if (baud_wrap) begin
              shift <= shift >> 1;
              if (last_data) begin
                bit_cnt <= '0;
                state   <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_PAR: begin
            if (baud_wrap) state <= ST_STOP;
          end
          ST_STOP: begin
            if (baud_wrap) begin
              if (last_stop) state <= ST_IDLE;
              else           bit_cnt <= bit_cnt + 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo across several parameter sets.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tb_data;
  logic [4:0] vld;
  logic [4:0] rdy;
  logic [4:0] txd;
  logic [4:0] bsy;
  logic [2:0] cnt [5];

  int          checks = 0;
  int          errors = 0;
  int unsigned sel    = 0;
  logic        cap  [$];
  logic        capb [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
    .clk_i(clk), .rst_i(rst), .data_i(tb_data), .valid_i(vld[0]), .ready_o(rdy[0]),
    .uart_txd_o(txd[0]), .busy_o(bsy[0]), .fifo_count_o(cnt[0]));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
    .clk_i(clk), .rst_i(rst), .data_i(tb_data), .valid_i(vld[1]), .ready_o(rdy[1]),
    .uart_txd_o(txd[1]), .busy_o(bsy[1]), .fifo_count_o(cnt[1]));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8o1 (
    .clk_i(clk), .rst_i(rst), .data_i(tb_data), .valid_i(vld[2]), .ready_o(rdy[2]),
    .uart_txd_o(txd[2]), .busy_o(bsy[2]), .fifo_count_o(cnt[2]));

  uart_tx_fifo #(.CLK_HZ(1600), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_7n2 (
    .clk_i(clk), .rst_i(rst), .data_i(tb_data), .valid_i(vld[3]), .ready_o(rdy[3]),
    .uart_txd_o(txd[3]), .busy_o(bsy[3]), .fifo_count_o(cnt[3]));

  uart_tx_fifo #(.CLK_HZ(100_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_fast (
    .clk_i(clk), .rst_i(rst), .data_i(tb_data), .valid_i(vld[4]), .ready_o(rdy[4]),
    .uart_txd_o(txd[4]), .busy_o(bsy[4]), .fifo_count_o(cnt[4]));

  task automatic push_byte(input logic [7:0] d);
    tb_data  = d;
    vld[sel] = 1'b1;
    @(posedge clk);
    #1;
    vld[sel] = 1'b0;
  endtask

  task automatic capture(input int unsigned n);
    cap.delete();
    capb.delete();
    repeat (n) begin
      @(posedge clk);
      #1;
      cap.push_back(txd[sel]);
      capb.push_back(bsy[sel]);
    end
  endtask

  task automatic test_reset;
    rst     = 1'b1;
    vld     = '0;
    tb_data = '0;
    #1;
    checks++;
    if (txd !== 5'b11111 || rdy !== 5'b11111 || bsy !== 5'b00000 || cnt[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_async got txd=%b rdy=%b busy=%b cnt=%0d want 11111 11111 00000 0", txd, rdy, bsy, cnt[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (txd[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || cnt[0] !== 3'd0) begin
      errors++;
      $display("FAIL reset_release got txd=%b rdy=%b busy=%b cnt=%0d want 1 1 0 0", txd[0], rdy[0], bsy[0], cnt[0]);
    end
  endtask

  task automatic test_8n1;
    logic [0:9] exp;
    int         bad;
    exp = 10'b0_10100101_1;
    sel = 0;
    push_byte(8'hA5);
    checks++;
    if (cnt[0] !== 3'd1 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_push got cnt=%0d busy=%b want 1 1", cnt[0], bsy[0]);
    end
    capture(162);
    checks++;
    if (cap[0] !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_latency got txd=%b one edge after pop want 1", cap[0]);
    end
    for (int unsigned b = 0; b < 10; b++) begin
      bad = -1;
      for (int unsigned c = 0; c < 16; c++)
        if (bad < 0 && cap[1 + b * 16 + c] !== exp[b]) bad = int'(c);
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL 8n1_bit%0d got %b want %b at cycle %0d", b, cap[1 + b * 16 + bad], exp[b], bad);
      end
    end
    checks++;
    if (capb[159] !== 1'b1 || capb[160] !== 1'b0 || cap[161] !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_frame_len got busy=%b%b txd_after=%b want 10 1", capb[159], capb[160], cap[161]);
    end
  endtask

  task automatic test_formats;
    int unsigned fsel [3] = '{1, 2, 3};
    logic [7:0]  fbyte[3] = '{8'h07, 8'h07, 8'h80};
    logic [0:10] fexp [3] = '{11'b0_11100000_1_1, 11'b0_11100000_0_1, 11'b0_0000000_11_0};
    int unsigned fnb  [3] = '{11, 11, 10};
    int unsigned ffl  [3] = '{176, 176, 160};
    logic [0:10] exp;
    int          bad;
    for (int unsigned t = 0; t < 3; t++) begin
      sel = fsel[t];
      exp = fexp[t];
      push_byte(fbyte[t]);
      capture(ffl[t] + 2);
      for (int unsigned b = 0; b < fnb[t]; b++) begin
        bad = -1;
        for (int unsigned c = 0; c < 16; c++)
          if (bad < 0 && cap[1 + b * 16 + c] !== exp[b]) bad = int'(c);
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL fmt%0d_bit%0d got %b want %b at cycle %0d", t, b, cap[1 + b * 16 + bad], exp[b], bad);
        end
      end
      checks++;
      if (capb[ffl[t] - 1] !== 1'b1 || capb[ffl[t]] !== 1'b0) begin
        errors++;
        $display("FAIL fmt%0d_frame_len got busy=%b%b want 10 at %0d cycles", t, capb[ffl[t] - 1], capb[ffl[t]], ffl[t]);
      end
    end
  endtask

  task automatic test_divisor;
    int unsigned run;
    sel = 4;
    push_byte(8'hA5);
    capture(871);
    run = 0;
    for (int unsigned i = 1; i < 871; i++) begin
      if (cap[i] !== 1'b0) break;
      run++;
    end
    checks++;
    if (cap[0] !== 1'b1 || run != 868) begin
      errors++;
      $display("FAIL divisor_start got pre=%b low_cycles=%0d want 1 868", cap[0], run);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  b2b[6] = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C, 8'hC3};
    logic [0:9]  exp;
    int          bad;
    sel = 0;
    fork
      begin
        logic        r;
        logic        stalled;
        int unsigned waited;
        stalled = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
          tb_data = b2b[i];
          vld[0]  = 1'b1;
          waited  = 0;
          forever begin
            @(negedge clk);
            r = rdy[0];
            if (!r && !stalled) begin
              stalled = 1'b1;
              checks++;
              if (cnt[0] !== 3'd4) begin
                errors++;
                $display("FAIL b2b_ready_low got cnt=%0d want 4", cnt[0]);
              end
            end else if (r && stalled) begin
              stalled = 1'b0;
              checks++;
              if (cnt[0] !== 3'd3) begin
                errors++;
                $display("FAIL b2b_ready_rise got cnt=%0d want 3", cnt[0]);
              end
            end
            @(posedge clk);
            #1;
            if (r) break;
            waited++;
            if (waited > 400) begin
              checks++;
              errors++;
              $display("FAIL b2b_timeout got no ready for byte %0d want ready within 400 cycles", i);
              break;
            end
          end
          if (i == 1) begin
            checks++;
            if (cnt[0] !== 3'd1) begin
              errors++;
              $display("FAIL b2b_push_pop got cnt=%0d want 1", cnt[0]);
            end
          end
        end
        vld[0] = 1'b0;
      end
      capture(964);
    join
    checks++;
    if (cap[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_latency got txd=%b want 1", cap[1]);
    end
    for (int unsigned f = 0; f < 6; f++) begin
      exp[0] = 1'b0;
      for (int unsigned k = 0; k < 8; k++) exp[1 + k] = b2b[f][k];
      exp[9] = 1'b1;
      bad = -1;
      for (int unsigned b = 0; b < 10; b++)
        for (int unsigned c = 0; c < 16; c++)
          if (bad < 0 && cap[2 + f * 160 + b * 16 + c] !== exp[b]) bad = int'(b * 16 + c);
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL b2b_frame%0d got %b want %b at offset %0d", f, cap[2 + f * 160 + bad], exp[bad / 16], bad);
      end
    end
    checks++;
    if (capb[960] !== 1'b1 || capb[961] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_total_len got busy=%b%b want 10", capb[960], capb[961]);
    end
  endtask

  task automatic test_reset_midframe;
    logic [0:9] exp;
    int         bad;
    logic       idle_ok;
    sel = 0;
    push_byte(8'h5A);
    push_byte(8'hFF);
    repeat (57) @(posedge clk);
    #1;
    checks++;
    if (txd[0] !== 1'b0 || cnt[0] !== 3'd1) begin
      errors++;
      $display("FAIL midframe_bit2 got txd=%b cnt=%0d want 0 1", txd[0], cnt[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (txd[0] !== 1'b1 || cnt[0] !== 3'd0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset got txd=%b cnt=%0d busy=%b rdy=%b want 1 0 0 1", txd[0], cnt[0], bsy[0], rdy[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    capture(20);
    idle_ok = 1'b1;
    for (int unsigned i = 0; i < 20; i++)
      if (cap[i] !== 1'b1 || capb[i] !== 1'b0) idle_ok = 1'b0;
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL midframe_discard got activity after reset want idle line");
    end
    exp = 10'b0_00111100_1;
    push_byte(8'h3C);
    capture(162);
    bad = -1;
    for (int unsigned b = 0; b < 10; b++)
      for (int unsigned c = 0; c < 16; c++)
        if (bad < 0 && cap[1 + b * 16 + c] !== exp[b]) bad = int'(b * 16 + c);
    checks++;
    if (bad >= 0 || cap[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_refill got mismatch at offset %0d pre=%b want clean 0x3C frame", bad, cap[0]);
    end
    checks++;
    if (capb[159] !== 1'b1 || capb[160] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_refill_len got busy=%b%b want 10", capb[159], capb[160]);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog got no completion want finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_8n1;
    test_formats;
    test_divisor;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
